// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Round-robin arbiter that maps up to REQ_NUM execute-unit writeback
//   requests onto PORT_NUM physical-register-file write ports. Each cycle the
//   scan starts at rr_ptr. The first PORT_NUM valid requesters found are
//   granted, and the k-th grant goes to port k. Granted requests are
//   registered, so the write happens 1 cycle after acceptance.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   req_valid     per requester: a result is pending
//   req_phy_id    per requester: destination physical register
//   req_data      per requester: write data
//   req_ready     per requester: request accepted this cycle (combinational)
//   flush         commit flush: blocks grants and kills in-flight writes
//   wb_phyf_we    per port: write enable (registered we, masked by flush)
//   wb_phyf_id    per port: write address (registered)
//   wb_phyf_data  per port: write data (registered)
//   conflict_cnt  saturating count of cycles in which a valid request waited
//                 (present only when WB_PORT_ARBITER_PERF_EN is defined)

module wb_port_reg #(
    parameter int ID_WIDTH   = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gnt,
    input  logic [ID_WIDTH-1:0]   id,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  we_q,
    output logic [ID_WIDTH-1:0]   id_q,
    output logic [DATA_WIDTH-1:0] data_q
);
    // we follows the grant every cycle. id/data load only on a grant, so an
    // idle port keeps its last address and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            we_q <= gnt;
            if (gnt) begin
                id_q   <= id;
                data_q <= data;
            end
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int REQ_NUM    = 8,
    parameter int PORT_NUM   = 2,
    parameter int ID_WIDTH   = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQ_NUM-1:0]                  req_valid,
    input  logic [REQ_NUM-1:0][ID_WIDTH-1:0]    req_phy_id,
    input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [REQ_NUM-1:0]                  req_ready,
    input  logic                                flush,
    output logic [PORT_NUM-1:0]                 wb_phyf_we,
    output logic [PORT_NUM-1:0][ID_WIDTH-1:0]   wb_phyf_id,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wb_phyf_data
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]                         conflict_cnt
`endif
);
    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PTR_W-1:0]                rr_ptr, rr_nxt;
    logic [PTR_W:0]                  scan_sum;
    logic [PTR_W-1:0]                scan_idx;
    logic [PORT_NUM-1:0]             port_gnt;
    logic [PORT_NUM-1:0][PTR_W-1:0]  port_sel;
    logic [PORT_NUM-1:0]             we_q;
    int                              gnt_cnt;

    // Scan requesters from rr_ptr with wrap-around. Each valid requester found
    // takes the next free port, until all PORT_NUM ports are used. Reset and
    // flush both block the scan, so no grant is given and rr_ptr holds.
    always_comb begin
        req_ready = '0;
        port_gnt  = '0;
        port_sel  = '0;
        rr_nxt    = rr_ptr;
        gnt_cnt   = 0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (rst && !flush) begin
            for (int j = 0; j < REQ_NUM; j++) begin
                scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
                if (scan_sum >= (PTR_W+1)'(REQ_NUM))
                    scan_sum = scan_sum - (PTR_W+1)'(REQ_NUM);
                scan_idx = scan_sum[PTR_W-1:0];
                if (req_valid[scan_idx] && gnt_cnt < PORT_NUM) begin
                    req_ready[scan_idx] = 1'b1;
                    for (int k = 0; k < PORT_NUM; k++) begin
                        if (gnt_cnt == k) begin
                            port_gnt[k] = 1'b1;
                            port_sel[k] = scan_idx;
                        end
                    end
                    rr_nxt  = (scan_idx == PTR_W'(REQ_NUM-1)) ? '0 : scan_idx + 1'b1;
                    gnt_cnt = gnt_cnt + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= '0;
        else      rr_ptr <= rr_nxt;
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        wb_port_reg #(
            .ID_WIDTH   (ID_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_port (
            .clk    (clk),
            .rst    (rst),
            .gnt    (port_gnt[p]),
            .id     (req_phy_id[port_sel[p]]),
            .data   (req_data[port_sel[p]]),
            .we_q   (we_q[p]),
            .id_q   (wb_phyf_id[p]),
            .data_q (wb_phyf_data[p])
        );
        // A result accepted one cycle before a flush must not reach the
        // register file, so the flush masks the registered enable.
        assign wb_phyf_we[p] = we_q[p] & ~flush;
    end

`ifdef WB_PORT_ARBITER_PERF_EN
    logic any_wait;
    assign any_wait = |(req_valid & ~req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            conflict_cnt <= '0;
        else if (!flush && any_wait && conflict_cnt != 32'hFFFF_FFFF)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int REQ_NUM    = 8;
    localparam int PORT_NUM   = 2;
    localparam int ID_WIDTH   = 6;
    localparam int DATA_WIDTH = 32;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [REQ_NUM-1:0]                  req_valid;
    logic [REQ_NUM-1:0][ID_WIDTH-1:0]    req_phy_id;
    logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  req_data;
    logic [REQ_NUM-1:0]                  req_ready;
    logic                                flush;
    logic [PORT_NUM-1:0]                 wb_phyf_we;
    logic [PORT_NUM-1:0][ID_WIDTH-1:0]   wb_phyf_id;
    logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wb_phyf_data;
`ifdef WB_PORT_ARBITER_PERF_EN
    logic [31:0]                         conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .REQ_NUM    (REQ_NUM),
        .PORT_NUM   (PORT_NUM),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_phy_id   (req_phy_id),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flush        (flush),
        .wb_phyf_we   (wb_phyf_we),
        .wb_phyf_id   (wb_phyf_id),
        .wb_phyf_data (wb_phyf_data)
`ifdef WB_PORT_ARBITER_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: cross the rising edge, then settle on the falling edge,
    // where inputs are changed and outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks both port registers. Requester i carries id 10+i and data 0x100+i.
    task automatic chk_ports(input string tag, input logic [1:0] we,
                             input int r0, input int r1);
        check({tag, ".we"},  64'(wb_phyf_we), 64'(we));
        check({tag, ".id0"}, 64'(wb_phyf_id[0]), 64'(10 + r0));
        check({tag, ".id1"}, 64'(wb_phyf_id[1]), 64'(10 + r1));
        check({tag, ".d0"},  64'(wb_phyf_data[0]), 64'(32'h100 + r0));
        check({tag, ".d1"},  64'(wb_phyf_data[1]), 64'(32'h100 + r1));
    endtask

    logic [7:0] rdy_seq [4] = '{8'h03, 8'h0C, 8'h30, 8'hC0};

    initial begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req_phy_id[i] = ID_WIDTH'(10 + i);
            req_data[i]   = DATA_WIDTH'(32'h100 + i);
        end
        rst = 1'b0; flush = 1'b0; req_valid = 8'hFF;
        step(); step();
        // Reset: no grants and all port registers are cleared.
        check("rst.ready", 64'(req_ready), 64'h0);
        check("rst.we",    64'(wb_phyf_we), 64'h0);
        check("rst.id",    64'(wb_phyf_id), 64'h0);
        check("rst.data",  64'(wb_phyf_data), 64'h0);

        // Requesters 0 and 7 are both granted, and rr_ptr wraps back to 0.
        rst = 1'b1; req_valid = 8'h81;
        #1 check("r81.ready", 64'(req_ready), 64'h81);
        step();
        chk_ports("r81", 2'b11, 0, 7);

        // All valid: pairs are granted in rotation, starting at 0.
        req_valid = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            #1 check($sformatf("rot%0d.ready", t), 64'(req_ready), 64'(rdy_seq[t]));
            step();
            chk_ports($sformatf("rot%0d", t), 2'b11, 2*t, 2*t+1);
        end

        // Grant requester 2, then flush on the next cycle.
        req_valid = 8'h04;
        #1 check("pre.ready", 64'(req_ready), 64'h04);
        step();
        check("pre.we", 64'(wb_phyf_we), 64'h1);
        flush = 1'b1; req_valid = 8'h30;
        #1 check("fl0.we",    64'(wb_phyf_we), 64'h0);
        check("fl0.ready", 64'(req_ready), 64'h0);
        step();
        check("fl1.ready", 64'(req_ready), 64'h0);
        check("fl1.we",    64'(wb_phyf_we), 64'h0);
        // rr_ptr was held at 3 through the flush. The scan starts at 3 and
        // wraps, so requesters 3 then 0 are granted.
        flush = 1'b0; req_valid = 8'h0B;
        #1 check("pf.we",    64'(wb_phyf_we), 64'h0);
        check("pf.ready", 64'(req_ready), 64'h09);
        step();
        chk_ports("pf", 2'b11, 3, 0);

        // Single grant: port1 turns off, and its id/data hold.
        req_valid = 8'h20;
        #1 check("one.ready", 64'(req_ready), 64'h20);
        step();
        chk_ports("one", 2'b01, 5, 0);

        // rr_ptr=6, so requesters 0 and 1 are granted first. Then reset mid-burst.
        req_valid = 8'h0F;
        #1 check("mb0.ready", 64'(req_ready), 64'h03);
        step();
        #1 check("mb1.ready", 64'(req_ready), 64'h0C);
        rst = 1'b0;
        #1 check("mbr.ready", 64'(req_ready), 64'h0);
        check("mbr.we",    64'(wb_phyf_we), 64'h0);
        check("mbr.id",    64'(wb_phyf_id), 64'h0);
        check("mbr.data",  64'(wb_phyf_data), 64'h0);
        step();
        rst = 1'b1;
        #1 check("rel.ready", 64'(req_ready), 64'h03);
        step();
        chk_ports("rel", 2'b11, 0, 1);
        req_valid = 8'h00;
        #1 check("idle.ready", 64'(req_ready), 64'h0);
        step();
        check("idle.we", 64'(wb_phyf_we), 64'h0);

`ifdef WB_PORT_ARBITER_PERF_EN
        rst = 1'b0;
        step();
        rst = 1'b1; req_valid = 8'h07;
        #1 check("pc.init", 64'(conflict_cnt), 64'h0);
        // Each cycle one of the three requesters waits. During the third
        // cycle the counter shows the two earlier waits.
        step(); step();
        check("pc.two", 64'(conflict_cnt), 64'd2);
        step();
        check("pc.three", 64'(conflict_cnt), 64'd3);
        req_valid = 8'h01;
        step();
        check("pc.nowait", 64'(conflict_cnt), 64'd3);
        req_valid = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
